// File: rtl/packet_source_arbiter.sv
// packet_source_arbiter: whole-packet round-robin sharing of one assembler stream with truncation at MAX_LEN
module packet_source_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 381,
  parameter int ID_W       = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_last,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          asm_valid,
  output logic [DATA_WIDTH-1:0]         asm_data,
  output logic                          asm_last,
  input  logic                          asm_done,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic [7:0]                    trunc_count
);
  typedef enum logic [1:0] {IDLE, FORWARD, DRAIN, WAIT_DONE} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, pick;
  logic [15:0] word_cnt;
  logic found, accept, fwd, at_max, g_last;
  logic [DATA_WIDTH-1:0] g_data;
  // first requester at or after rr_ptr, wrapping
  always_comb begin
    pick = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (!found && src_valid[ID_W'((int'(rr_ptr) + i) % NUM_SRC)]) begin
        pick = ID_W'((int'(rr_ptr) + i) % NUM_SRC);
        found = 1'b1;
      end
  end
  assign accept = src_valid[grant_id] & src_ready[grant_id];
  assign fwd    = (state == FORWARD) & accept;
  assign g_last = src_last[grant_id];
  assign g_data = src_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign at_max = word_cnt == 16'(MAX_LEN - 1);
  always_ff @(posedge clock) state <= reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = found ? FORWARD : IDLE;
      FORWARD:   state_nxt = !accept ? FORWARD : g_last ? WAIT_DONE : at_max ? DRAIN : FORWARD;
      DRAIN:     state_nxt = (accept && g_last) ? WAIT_DONE : DRAIN;
      WAIT_DONE: state_nxt = asm_done ? IDLE : WAIT_DONE;
      default:   state_nxt = IDLE;
    endcase
  end
  always_comb begin
    src_ready = (state == FORWARD || state == DRAIN) ? NUM_SRC'(1) << grant_id : '0;
    busy = state != IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr      <= '0;
      word_cnt    <= '0;
      grant_id    <= '0;
      asm_valid   <= 1'b0;
      asm_data    <= '0;
      asm_last    <= 1'b0;
      trunc_count <= '0;
    end else begin
      asm_valid <= fwd;
      asm_last  <= fwd & (g_last | at_max);
      if (fwd) asm_data <= g_data;
      if (accept) word_cnt <= word_cnt + 16'd1;
      if (state == IDLE && found) begin
        grant_id <= pick;
        word_cnt <= '0;
      end
      if (fwd && at_max && !g_last && trunc_count != 8'hff) trunc_count <= trunc_count + 8'd1;
      if (state == WAIT_DONE && asm_done) rr_ptr <= (grant_id == ID_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
    end
  end
endmodule

// File: tb/tb_packet_source_arbiter.sv
// tb_packet_source_arbiter: packet-level round-robin model checked against every forwarded beat
module tb_packet_source_arbiter;
  localparam int NUM = 4;
  localparam int DW  = 32;
  localparam int ML  = 381;
  typedef struct {logic [31:0] d; bit l; int s;} beat_t;
  logic clock = 1'b0, reset = 1'b1, asm_done = 1'b0;
  logic [NUM-1:0] src_valid = '0, src_last = '0, src_ready, acc_q = '0;
  logic [NUM*DW-1:0] src_data = '0;
  logic asm_valid, asm_last, busy;
  logic [DW-1:0] asm_data;
  logic [1:0] grant_id;
  logic [7:0] trunc_count;
  int checks = 0, errors = 0, beat_cnt = 0, last_cnt = 0, done_cnt = 0, mptr = 0, seq = 0;
  bit chk_en = 0, auto_done = 1, first_of_pkt = 1;
  beat_t exp_q[$];
  beat_t e;
  int obs_g[$];
  logic [32:0] src_q[NUM][$];
  int pend_len[NUM][$];
  int pend_base[NUM][$];

  packet_source_arbiter #(.NUM_SRC(NUM), .DATA_WIDTH(DW), .MAX_LEN(ML), .ID_W(2)) dut (
    .clock(clock), .reset(reset), .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(src_ready), .asm_valid(asm_valid), .asm_data(asm_data), .asm_last(asm_last),
    .asm_done(asm_done), .grant_id(grant_id), .busy(busy), .trunc_count(trunc_count));

  always #5 clock = ~clock;
  always @(posedge clock) acc_q <= src_valid & src_ready & {NUM{~reset}};

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clock) if (chk_en) begin
    if (asm_valid) begin
      if (exp_q.size() == 0) chk(0, "unexpected_beat", asm_data, 0);
      else begin
        e = exp_q.pop_front();
        chk(asm_data == e.d, "beat_data", asm_data, e.d);
        chk(asm_last == e.l, "beat_last", 32'(asm_last), 32'(e.l));
        chk(grant_id == e.s, "beat_src", 32'(grant_id), 32'(e.s));
      end
      if (first_of_pkt) obs_g.push_back(int'(grant_id));
      first_of_pkt = asm_last;
      beat_cnt++;
      if (asm_last) last_cnt++;
    end
    chk((src_ready & ~(4'b1 << grant_id)) == 0 && (busy || src_ready == 0), "ready_rule", 32'(src_ready), 32'(grant_id));
  end

  function automatic bit src_pending();
    for (int i = 0; i < NUM; i++) if (src_q[i].size() != 0) return 1;
    return 0;
  endfunction

  function automatic bit model_pending();
    for (int i = 0; i < NUM; i++) if (pend_len[i].size() != 0) return 1;
    return 0;
  endfunction

  task automatic add_pkt(input int s, input int len);
    int base;
    base = (s << 28) | (seq << 16);
    seq++;
    for (int k = 0; k < len; k++) src_q[s].push_back({k == len - 1, 32'(base + k)});
    pend_len[s].push_back(len);
    pend_base[s].push_back(base);
  endtask

  // serve every pending packet in whole-packet round-robin order, truncating at ML words
  task automatic model_run();
    int s, n, base;
    bit f;
    while (model_pending()) begin
      f = 0;
      s = 0;
      for (int k = 0; k < NUM; k++)
        if (!f && pend_len[(mptr + k) % NUM].size() != 0) begin
          s = (mptr + k) % NUM;
          f = 1;
        end
      n = pend_len[s].pop_front();
      base = pend_base[s].pop_front();
      if (n > ML) n = ML;
      for (int k = 0; k < n; k++) exp_q.push_back('{32'(base + k), k == n - 1, s});
      mptr = (s + 1) % NUM;
    end
  endtask

  task automatic tick();
    logic [32:0] w;
    @(negedge clock);
    #1;
    for (int i = 0; i < NUM; i++) if (acc_q[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    for (int i = 0; i < NUM; i++) begin
      w = src_q[i].size() != 0 ? src_q[i][0] : 33'd0;
      src_valid[i] = src_q[i].size() != 0;
      src_last[i] = w[32];
      src_data[i*DW +: DW] = w[31:0];
    end
    if (auto_done) begin
      asm_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) asm_done = 1'b1;
      end
      if (asm_valid && asm_last) done_cnt = 3;
    end
  endtask

  task automatic drain(input int bound);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy || src_pending()) && c < bound) begin
      tick();
      c++;
    end
    chk(c < bound, "drain_timeout", 32'(c), 32'(bound));
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM; i++) begin
      src_q[i].delete();
      pend_len[i].delete();
      pend_base[i].delete();
    end
    exp_q.delete();
    mptr = 0;
    first_of_pkt = 1;
    done_cnt = 0;
    asm_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    clear_all();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    repeat (3) tick();
    chk(asm_valid == 0 && asm_last == 0, "rst_asm_ctl", {asm_valid, asm_last}, 0);
    chk(asm_data == 0, "rst_asm_data", asm_data, 0);
    chk(grant_id == 0, "rst_grant", 32'(grant_id), 0);
    chk(busy == 0, "rst_busy", 32'(busy), 0);
    chk(trunc_count == 0, "rst_trunc", 32'(trunc_count), 0);
    chk(src_ready == 0, "rst_ready", 32'(src_ready), 0);
    chk_en = 1;
    reset = 1'b0;
    // single packet from src1
    add_pkt(1, 3);
    model_run();
    tick();
    tick();
    chk(grant_id == 1, "single_grant", 32'(grant_id), 1);
    chk(src_ready == 4'b0010, "single_ready", 32'(src_ready), 2);
    drain(100);
    chk(asm_data == 32'h1000_0002, "single_hold_data", asm_data, 32'h1000_0002);
    chk(beat_cnt == 3 && last_cnt == 1, "single_beats", 32'(beat_cnt), 3);
    chk(obs_g.size() == 1 && obs_g[0] == 1, "single_order", 32'(obs_g.size()), 1);
    // rr_ptr is now 2: src2 wins over src0
    obs_g.delete();
    add_pkt(0, 2);
    add_pkt(2, 2);
    model_run();
    drain(100);
    chk(obs_g.size() == 2 && obs_g[0] == 2 && obs_g[1] == 0, "ptr2_order", 32'(obs_g[0]), 2);
    // contention from reset: src0 before src2
    do_reset();
    obs_g.delete();
    add_pkt(0, 4);
    add_pkt(2, 3);
    model_run();
    drain(100);
    chk(obs_g.size() == 2 && obs_g[0] == 0 && obs_g[1] == 2, "contend_order", 32'(obs_g[0]), 0);
    // fairness: all sources, two 2-word packets each
    do_reset();
    obs_g.delete();
    for (int s = 0; s < NUM; s++) begin
      add_pkt(s, 2);
      add_pkt(s, 2);
    end
    model_run();
    drain(300);
    chk(obs_g.size() == 8, "fair_count", 32'(obs_g.size()), 8);
    for (int k = 0; k < 8; k++) chk(obs_g[k] == k % NUM, "fair_order", 32'(obs_g[k]), 32'(k % NUM));
    // truncation: 383 words -> 381 forwarded, then exact-length packet
    beat_cnt = 0;
    last_cnt = 0;
    add_pkt(3, 383);
    model_run();
    drain(2000);
    chk(beat_cnt == 381 && last_cnt == 1, "trunc_beats", 32'(beat_cnt), 381);
    chk(trunc_count == 1, "trunc_count1", 32'(trunc_count), 1);
    chk(asm_data[15:0] == 16'd380, "trunc_last_word", asm_data, 380);
    beat_cnt = 0;
    add_pkt(3, 381);
    model_run();
    drain(2000);
    chk(beat_cnt == 381, "exact_beats", 32'(beat_cnt), 381);
    chk(trunc_count == 1, "exact_no_trunc", 32'(trunc_count), 1);
    // hold for done
    auto_done = 0;
    add_pkt(1, 2);
    model_run();
    c = 0;
    while (!(asm_valid && asm_last) && c < 20) begin
      tick();
      c++;
    end
    chk(c < 20, "hold_last_timeout", 32'(c), 20);
    add_pkt(0, 2);
    model_run();
    for (int k = 0; k < 50; k++) begin
      tick();
      chk(src_ready == 0, "hold_ready", 32'(src_ready), 0);
      chk(busy == 1, "hold_busy", 32'(busy), 1);
    end
    asm_done = 1'b1;
    tick();
    asm_done = 1'b0;
    chk(busy == 0 && src_ready == 0, "done_idle", 32'(busy), 0);
    tick();
    chk(grant_id == 0 && src_ready == 4'b0001 && busy == 1, "done_regrant", 32'(src_ready), 1);
    auto_done = 1;
    drain(100);
    // reset mid-packet after 2 of 5 words
    beat_cnt = 0;
    last_cnt = 0;
    add_pkt(2, 5);
    model_run();
    c = 0;
    while (beat_cnt < 2 && c < 20) begin
      tick();
      c++;
    end
    chk(beat_cnt == 2, "mid_two_beats", 32'(beat_cnt), 2);
    reset = 1'b1;
    tick();
    chk(asm_valid == 0 && asm_last == 0 && asm_data == 0, "mid_asm_zero", asm_data, 0);
    chk(grant_id == 0 && busy == 0 && src_ready == 0, "mid_ctl_zero", {grant_id, busy, src_ready}, 0);
    chk(trunc_count == 0, "mid_trunc_zero", 32'(trunc_count), 0);
    clear_all();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk(last_cnt == 0 && busy == 0, "mid_no_last", 32'(last_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/packet_source_arbiter.md
Name: packet_source_arbiter

Overview:
- Shares one packet_assembler input stream between NUM_SRC upstream packet sources.
- Arbitration is whole-packet round-robin: once a source is granted, every word up to and including its last word is forwarded before any other source is considered.
- The assembler has no backpressure, so the next grant waits until the assembler reports footer completion (asm_done).
- Packets longer than MAX_LEN words are truncated to MAX_LEN; the remaining source words are drained and counted.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DATA_WIDTH, 32, word width.
- MAX_LEN, 381, maximum payload words forwarded per packet (assembler buffer depth).
- ID_W, 2, grant index width; must be >= clog2(NUM_SRC).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source word valid.
- src_data  in  NUM_SRC*DATA_WIDTH  per-source word; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_last  in  NUM_SRC  per-source last word of packet.
- src_ready  out  NUM_SRC  per-source accept (combinational from state and grant).
- asm_valid  out  1  word valid to assembler (registered).
- asm_data  out  DATA_WIDTH  word to assembler (registered).
- asm_last  out  1  last word to assembler (registered).
- asm_done  in  1  assembler footer beat (its validOut & lastOut).
- grant_id  out  ID_W  currently or most recently granted source.
- busy  out  1  high whenever state != IDLE.
- trunc_count  out  8  saturating count of truncated packets.

Behaviour:
- Reset (synchronous, dominates all other inputs):
  - state=IDLE, rr_ptr=0, word_cnt=0.
  - asm_valid, asm_data, asm_last, grant_id, busy, trunc_count and src_ready all 0.
- States: IDLE, FORWARD, DRAIN, WAIT_DONE.
- IDLE:
  - src_ready = 0.
  - If any src_valid is high, grant the first requester found scanning upward from rr_ptr with wrap-around.
  - Latch grant_id, clear word_cnt, go to FORWARD on the next cycle.
  - No requester: stay in IDLE.
- FORWARD:
  - src_ready[grant_id] = 1; all other ready bits 0.
  - A beat is accepted when src_valid[g] & src_ready[g].
  - Each accepted beat registers asm_valid=1 and asm_data=src_data[g] on the same edge, so it appears one cycle after acceptance. word_cnt increments.
  - asm_last = src_last[g] OR (word_cnt == MAX_LEN-1).
  - A cycle with no accepted beat registers asm_valid=0, asm_last=0; asm_data holds its value.
  - Accepted beat with src_last → WAIT_DONE.
  - Accepted beat with word_cnt == MAX_LEN-1 and src_last=0 → asm_last forced to 1, trunc_count+1 (saturates at 255), go to DRAIN.
- DRAIN:
  - src_ready[g] = 1; accepted beats are discarded and asm_valid = 0.
  - Accepted beat with src_last → WAIT_DONE.
- WAIT_DONE:
  - src_ready = 0; asm_valid registers 0.
  - On asm_done=1 → IDLE, with rr_ptr = (grant_id+1) mod NUM_SRC.
  - asm_done seen in any other state is ignored.
- Minimum gap between two granted packets: last beat, +1 (asm register), + assembler header/payload/footer cycles, +1 (return to IDLE), +1 (new grant).
- Word counting:
  - word_cnt is 16 bits.
  - A packet of exactly MAX_LEN words with src_last on the final word is not truncated and does not increment trunc_count.
- src_valid may drop mid-packet; the grant holds indefinitely, with no timeout.
- grant_id retains its value in IDLE; busy is derived combinationally from state.
- Reset asserted mid-packet:
  - Packet is abandoned; no asm_last is emitted.
  - Source words still in flight are seen as a new packet after reset.

Test Plan:
- Single packet: src1 sends A0,A1,A2 (last on A2) → grant_id=1; asm_valid high 3 cycles with A0..A2; asm_last only with A2; asm_done pulse → IDLE, rr_ptr=2.
- Contention: src0 and src2 request simultaneously from reset (rr_ptr=0) → src0 served first; after its asm_done, src2 granted; src2 src_ready stays 0 throughout src0's packet.
- Round-robin fairness: all 4 sources continuously requesting 2-word packets → grant order 0,1,2,3,0; no source granted twice before others.
- Truncation: src3 sends 383 words, last on word 383 → 381 words forwarded, asm_last on word 381; words 382–383 accepted but not forwarded; trunc_count=1. A follow-up 381-word packet leaves trunc_count at 1.
- Hold for done: last beat forwarded, asm_done held low 50 cycles while src0 requests → src_ready all 0 and busy=1 for those 50 cycles; src0 granted 2 cycles after asm_done.
- Reset mid-packet: reset asserted after 2 of 5 words → next cycle all outputs 0, state IDLE, trunc_count=0, no asm_last emitted.
